// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the gshare checkpointing predictor.
// Counter helpers work on a wide container; callers truncate to their CTR_BITS.
package bp_pkg;

    localparam int unsigned CtrMaxW = 8;

    typedef logic [CtrMaxW-1:0] ctr_wide_t;

    function automatic ctr_wide_t ctr_max(input int unsigned bits);
        return ctr_wide_t'((32'd1 << bits) - 32'd1);
    endfunction

    // Weakly not-taken: the largest value whose MSB is still clear.
    function automatic ctr_wide_t ctr_weak_nt(input int unsigned bits);
        return ctr_wide_t'((32'd1 << (bits - 1)) - 32'd1);
    endfunction

    function automatic ctr_wide_t ctr_sat_inc(input ctr_wide_t c, input int unsigned bits);
        ctr_wide_t top;
        top = ctr_max(bits);
        return (c >= top) ? top : c + ctr_wide_t'(1);
    endfunction

    function automatic ctr_wide_t ctr_sat_dec(input ctr_wide_t c);
        return (c == '0) ? '0 : c - ctr_wide_t'(1);
    endfunction

endpackage

// File: rtl/bp_gshare_ckpt_if.sv
// Fetch/retire bundle between the front end and the gshare checkpointing predictor.
interface bp_gshare_ckpt_if #(
    parameter int unsigned CKPT_DEPTH = 16
);
    localparam int unsigned TagW = $clog2(CKPT_DEPTH);

    logic            enable;
    logic            mode_gshare;
    logic            if_branch;
    logic [31:0]     if_pc;
    logic            pred_valid;
    logic            pred_taken;
    logic [TagW-1:0] pred_tag;
    logic            if_stall;
    logic            rt_valid;
    logic            rt_taken;
    logic            rt_mispredict;
    logic [TagW-1:0] rt_tag;
    logic [TagW:0]   occupancy;
    logic            protocol_err;

    modport master (
        output enable, mode_gshare, if_branch, if_pc, rt_valid, rt_taken, rt_mispredict, rt_tag,
        input  pred_valid, pred_taken, pred_tag, if_stall, occupancy, protocol_err
    );

    modport slave (
        input  enable, mode_gshare, if_branch, if_pc, rt_valid, rt_taken, rt_mispredict, rt_tag,
        output pred_valid, pred_taken, pred_tag, if_stall, occupancy, protocol_err
    );

endinterface

// File: rtl/bp_ckpt_queue.sv
// Circular checkpoint FIFO: allocate at tail, retire at head, flush empties to head+1.
module bp_ckpt_queue
    import bp_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 16,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned OccW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_i,
    input  logic [Width-1:0] alloc_data_i,
    input  logic             retire_i,
    input  logic             flush_i,
    output logic [PtrW-1:0]  head_o,
    output logic [PtrW-1:0]  tail_o,
    output logic [OccW-1:0]  occ_o,
    output logic [Width-1:0] head_data_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [OccW-1:0]  occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            // Flush retires the head and discards everything younger.
            head_d = head_q + PtrW'(1);
            tail_d = head_q + PtrW'(1);
            occ_d  = '0;
        end else begin
            if (retire_i) head_d = head_q + PtrW'(1);
            if (alloc_i)  tail_d = tail_q + PtrW'(1);
            case ({alloc_i, retire_i})
                2'b10:   occ_d = occ_q + OccW'(1);
                2'b01:   occ_d = occ_q - OccW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (alloc_i) mem_q[tail_q] <= alloc_data_i;
        end
    end

    assign head_o      = head_q;
    assign tail_o      = tail_q;
    assign occ_o       = occ_q;
    assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/bp_gshare_ckpt.sv
// Gshare/bimodal direction predictor with per-branch history checkpoints and
// single-cycle history recovery on a mispredicted retire.
module bp_gshare_ckpt
    import bp_pkg::*;
#(
    parameter int unsigned BH_SIZE    = 8,
    parameter int unsigned CKPT_DEPTH = 16,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned PC_SHIFT   = 2
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    bp_gshare_ckpt_if.slave       bp_io
);

    localparam int unsigned TagW = $clog2(CKPT_DEPTH);
    localparam int unsigned PhtN = 1 << BH_SIZE;

    typedef struct packed {
        logic [BH_SIZE-1:0] hist;
        logic [BH_SIZE-1:0] idx;
    } bp_ckpt_t;

    logic [CTR_BITS-1:0] pht_q [PhtN];
    logic [BH_SIZE-1:0]  ghr_q, ghr_d;
    logic                err_q, err_d;

    logic [BH_SIZE-1:0]  idx;
    logic                pred_taken, pred_valid, full;
    logic                rt_fire, legal, retire_ok, recover;
    logic [TagW-1:0]     head, tail;
    logic [TagW:0]       occ;
    bp_ckpt_t            alloc_ck, head_ck;
    logic [CTR_BITS-1:0] ctr_cur, ctr_next;
    logic                unused_pc;

    assign idx        = bp_io.if_pc[PC_SHIFT +: BH_SIZE] ^ (bp_io.mode_gshare ? ghr_q : '0);
    assign pred_taken = pht_q[idx][CTR_BITS-1];
    assign unused_pc  = ^bp_io.if_pc;

    // Full is judged from registered occupancy only; a same-cycle retire does not unstall.
    assign full       = (occ == (TagW+1)'(CKPT_DEPTH));
    assign rt_fire    = bp_io.enable & bp_io.rt_valid;
    assign legal      = (occ != '0) & (bp_io.rt_tag == head);
    assign retire_ok  = rt_fire & legal;
    assign recover    = retire_ok & bp_io.rt_mispredict;
    assign pred_valid = bp_io.enable & bp_io.if_branch & ~full & ~recover;

    assign alloc_ck.hist = ghr_q;
    assign alloc_ck.idx  = idx;

    bp_ckpt_queue #(
        .Depth (CKPT_DEPTH),
        .Width ($bits(bp_ckpt_t))
    ) u_ckpt_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_i      (pred_valid),
        .alloc_data_i (alloc_ck),
        .retire_i     (retire_ok),
        .flush_i      (recover),
        .head_o       (head),
        .tail_o       (tail),
        .occ_o        (occ),
        .head_data_o  (head_ck)
    );

    // Training uses the index captured at prediction time, so mode changes are harmless.
    assign ctr_cur  = pht_q[head_ck.idx];
    assign ctr_next = bp_io.rt_taken ? CTR_BITS'(ctr_sat_inc(CtrMaxW'(ctr_cur), CTR_BITS))
                                     : CTR_BITS'(ctr_sat_dec(CtrMaxW'(ctr_cur)));

    always_comb begin
        ghr_d = ghr_q;
        err_d = err_q | (rt_fire & ~legal);
        if (recover) begin
            ghr_d = {head_ck.hist[BH_SIZE-2:0], bp_io.rt_taken};
        end else if (pred_valid) begin
            ghr_d = {ghr_q[BH_SIZE-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < int'(PhtN); i++) pht_q[i] <= CTR_BITS'(ctr_weak_nt(CTR_BITS));
        end else begin
            ghr_q <= ghr_d;
            err_q <= err_d;
            if (retire_ok) pht_q[head_ck.idx] <= ctr_next;
        end
    end

    assign bp_io.pred_valid   = pred_valid;
    assign bp_io.pred_taken   = pred_taken;
    assign bp_io.pred_tag     = tail;
    assign bp_io.if_stall     = full;
    assign bp_io.occupancy    = occ;
    assign bp_io.protocol_err = err_q;

endmodule

// File: tb/tb_bp_gshare_ckpt.sv
// Scoreboard bench for bp_gshare_ckpt: a reference model predicts each cycle's outputs,
// which are queued and compared when the DUT's outputs are sampled.
`timescale 1ns/1ps
module tb_bp_gshare_ckpt;

    localparam int unsigned BH    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CB    = 2;
    localparam int unsigned PS    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bp_gshare_ckpt_if #(.CKPT_DEPTH(DEPTH)) bp_if ();

    bp_gshare_ckpt #(
        .BH_SIZE    (BH),
        .CKPT_DEPTH (DEPTH),
        .CTR_BITS   (CB),
        .PC_SHIFT   (PS)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bp_io  (bp_if)
    );

    typedef struct {
        logic       pv;
        logic       pt;
        logic [1:0] tag;
        logic       stall;
        logic [2:0] occ;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    int         m_pht [16];
    logic [3:0] m_ghr;
    logic [1:0] m_head, m_tail;
    int         m_occ;
    logic       m_err;
    logic [3:0] m_hist [4];
    logic [3:0] m_idx  [4];

    logic       obs_pv, obs_pt;
    logic [1:0] obs_tag;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        m_ghr  = '0;
        m_head = '0;
        m_tail = '0;
        m_occ  = 0;
        m_err  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0;
            m_idx[i]  = '0;
        end
    endtask

    task automatic idle_inputs();
        bp_if.enable        = 1'b1;
        bp_if.mode_gshare   = 1'b1;
        bp_if.if_branch     = 1'b0;
        bp_if.if_pc         = '0;
        bp_if.rt_valid      = 1'b0;
        bp_if.rt_taken      = 1'b0;
        bp_if.rt_mispredict = 1'b0;
        bp_if.rt_tag        = '0;
    endtask

    // Called at posedge+1; leaves the bench at the following posedge+1.
    task automatic step(input logic en, input logic gs, input logic br, input logic [31:0] pc,
                        input logic rv, input logic rt, input logic rm, input logic [1:0] rtag);
        exp_t       e, o;
        logic [3:0] idx, ghr0, ridx;
        logic       pt, pv, legal, fire, rec;
        bp_if.enable        = en;
        bp_if.mode_gshare   = gs;
        bp_if.if_branch     = br;
        bp_if.if_pc         = pc;
        bp_if.rt_valid      = rv;
        bp_if.rt_taken      = rt;
        bp_if.rt_mispredict = rm;
        bp_if.rt_tag        = rtag;
        ghr0    = m_ghr;
        idx     = pc[5:2] ^ (gs ? m_ghr : 4'd0);
        pt      = (m_pht[idx] >= 2);
        legal   = (m_occ != 0) && (rtag == m_head);
        fire    = en && rv;
        rec     = fire && legal && rm;
        pv      = en && br && (m_occ != 4) && !rec;
        e.pv    = pv;
        e.pt    = pt;
        e.tag   = m_tail;
        e.stall = (m_occ == 4);
        e.occ   = 3'(m_occ);
        e.err   = m_err;
        exp_q.push_back(e);
        @(negedge clk);
        o       = exp_q.pop_front();
        obs_pv  = bp_if.pred_valid;
        obs_pt  = bp_if.pred_taken;
        obs_tag = bp_if.pred_tag;
        chk_eq("pred_valid", 32'(bp_if.pred_valid), 32'(o.pv));
        chk_eq("pred_taken", 32'(bp_if.pred_taken), 32'(o.pt));
        if (o.pv) chk_eq("pred_tag", 32'(bp_if.pred_tag), 32'(o.tag));
        chk_eq("if_stall", 32'(bp_if.if_stall), 32'(o.stall));
        chk_eq("occupancy", 32'(bp_if.occupancy), 32'(o.occ));
        chk_eq("protocol_err", 32'(bp_if.protocol_err), 32'(o.err));
        @(posedge clk);
        if (fire && !legal) m_err = 1'b1;
        if (fire && legal) begin
            ridx = m_idx[m_head];
            if (rt) m_pht[ridx] = (m_pht[ridx] < 3) ? m_pht[ridx] + 1 : 3;
            else    m_pht[ridx] = (m_pht[ridx] > 0) ? m_pht[ridx] - 1 : 0;
            if (rm) begin
                m_ghr  = {m_hist[m_head][2:0], rt};
                m_head = m_head + 2'd1;
                m_tail = m_head;
                m_occ  = 0;
            end else begin
                m_head = m_head + 2'd1;
                m_occ  = m_occ - 1;
            end
        end
        if (pv) begin
            m_hist[m_tail] = ghr0;
            m_idx[m_tail]  = idx;
            m_tail         = m_tail + 2'd1;
            m_ghr          = {ghr0[2:0], pt};
            m_occ          = m_occ + 1;
        end
        #1;
        chk_eq("ghr", 32'(dut.ghr_q), 32'(m_ghr));
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        chk_eq("rst_pred_valid", 32'(bp_if.pred_valid), 32'd0);
        chk_eq("rst_if_stall", 32'(bp_if.if_stall), 32'd0);
        chk_eq("rst_occupancy", 32'(bp_if.occupancy), 32'd0);
        chk_eq("rst_protocol_err", 32'(bp_if.protocol_err), 32'd0);
        do_reset();

        // Reset state and first prediction, then counter training 01->10->11.
        step(1, 1, 1, 32'h30, 0, 0, 0, 0);
        chk_eq("first_pv", 32'(obs_pv), 32'd1);
        chk_eq("first_pt", 32'(obs_pt), 32'd0);
        chk_eq("first_tag", 32'(obs_tag), 32'd0);
        chk_eq("first_ghr", 32'(dut.ghr_q), 32'h0);
        chk_eq("first_occ", 32'(bp_if.occupancy), 32'd1);
        step(1, 0, 0, 32'h0, 1, 1, 1, 0);
        step(1, 0, 1, 32'h30, 0, 0, 0, 0);
        chk_eq("train1_pt", 32'(obs_pt), 32'd1);
        step(1, 0, 0, 32'h0, 1, 1, 0, 1);
        step(1, 0, 1, 32'h30, 0, 0, 0, 0);
        chk_eq("train2_pt", 32'(obs_pt), 32'd1);
        chk_eq("train_ctr", 32'(dut.pht_q[12]), 32'd3);
        step(1, 0, 0, 32'h0, 1, 0, 1, 2);
        chk_eq("dec_ctr", 32'(dut.pht_q[12]), 32'd2);

        // Full and stall.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 32'(i * 4), 0, 0, 0, 0);
            chk_eq("full_tag", 32'(obs_tag), 32'(i));
        end
        chk_eq("full_occ", 32'(bp_if.occupancy), 32'd4);
        chk_eq("full_stall", 32'(bp_if.if_stall), 32'd1);
        step(1, 1, 1, 32'h44, 0, 0, 0, 0);
        chk_eq("full_drop_pv", 32'(obs_pv), 32'd0);
        chk_eq("full_drop_ghr", 32'(dut.ghr_q), 32'h0);
        step(1, 1, 0, 32'h0, 1, 0, 0, 0);
        chk_eq("unstall", 32'(bp_if.if_stall), 32'd0);
        chk_eq("unstall_occ", 32'(bp_if.occupancy), 32'd3);

        // Mispredict recovery.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'(32'h10 + i * 4), 0, 0, 0, 0);
        step(1, 1, 0, 32'h0, 1, 1, 1, 0);
        chk_eq("rec_ghr", 32'(dut.ghr_q), 32'h1);
        chk_eq("rec_occ", 32'(bp_if.occupancy), 32'd0);
        step(1, 1, 1, 32'h20, 0, 0, 0, 0);
        chk_eq("rec_next_tag", 32'(obs_tag), 32'd1);

        // Pointer wrap with alloc+retire every cycle, then alloc against a mispredict.
        do_reset();
        step(1, 1, 1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, 32'(i * 8), 1, 0, 0, 2'(i));
            chk_eq("wrap_tag", 32'(obs_tag), 32'((i + 1) % 4));
            chk_eq("wrap_occ", 32'(bp_if.occupancy), 32'd1);
        end
        step(1, 1, 1, 32'h30, 1, 1, 1, 2);
        chk_eq("coinc_pv", 32'(obs_pv), 32'd0);
        chk_eq("coinc_occ", 32'(bp_if.occupancy), 32'd0);

        // Enable low freezes state, even for an illegal retire.
        step(0, 1, 1, 32'h30, 1, 0, 0, 1);
        chk_eq("dis_pv", 32'(obs_pv), 32'd0);
        chk_eq("dis_err", 32'(bp_if.protocol_err), 32'd0);

        // Protocol errors and asynchronous reset.
        do_reset();
        step(1, 1, 0, 32'h0, 1, 0, 0, 0);
        chk_eq("err_empty", 32'(bp_if.protocol_err), 32'd1);
        step(1, 1, 1, 32'h30, 0, 0, 0, 0);
        step(1, 1, 0, 32'h0, 1, 1, 1, 3);
        chk_eq("err_sticky", 32'(bp_if.protocol_err), 32'd1);
        chk_eq("err_occ", 32'(bp_if.occupancy), 32'd1);
        step(1, 1, 1, 32'h34, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("async_err", 32'(bp_if.protocol_err), 32'd0);
        chk_eq("async_occ", 32'(bp_if.occupancy), 32'd0);
        chk_eq("async_ghr", 32'(dut.ghr_q), 32'h0);
        do_reset();

        // Random traffic against the model, mostly legal retires.
        for (int i = 0; i < 200; i++) begin
            logic [1:0] rtag;
            rtag = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : m_head;
            step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), rtag);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
